// File: rtl/lsc_pkg.sv
// Shared types and constants for the LFSR stream cipher.
// The optional LSC_CFG_CHECK_EN build uses the maximal-tap table defined here.
package lsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] PAD_CHAR_DEF = 8'h20;

    // Known maximal-length tap masks for an 8-bit LFSR.
    localparam logic [7:0] MAX_TAPS8 [8] = '{
        8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
    };

    function automatic logic is_max_taps8(input logic [7:0] taps);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (taps == MAX_TAPS8[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/lfsr_stream_cipher_if.sv
// Byte-stream valid/ready interface for the stream cipher: input side and output side.
interface lfsr_stream_cipher_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lsc_lfsr.sv
// W-bit Fibonacci-style LFSR: shifts left, feedback is parity of (state & taps).
// Load has priority over step.
module lsc_lfsr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    input  logic [W-1:0] taps,
    output logic [W-1:0] q
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & taps)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher: frames (encrypt) or de-frames (decrypt) a FRAME-byte run, XORing each
// position with successive LFSR states. Define LSC_CFG_CHECK_EN to reject bad seed/tap configs.
module lfsr_stream_cipher
    import lsc_pkg::*;
#(
    parameter int unsigned  W        = 8,
    parameter int unsigned  FRAME    = 64,
    parameter logic [W-1:0] PAD_CHAR = W'(PAD_CHAR_DEF),
    localparam int unsigned PW       = $clog2(FRAME + 1)
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  start,
    input  logic                  cfg_mode,
    input  logic [W-1:0]          cfg_taps,
    input  logic [W-1:0]          cfg_seed,
    input  logic [PW-1:0]         cfg_pre,
    lfsr_stream_cipher_if.slave   bus,
    output logic                  done,
    output logic                  err
);

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          mode_q, mode_d;
    logic          msg_end_q, msg_end_d;
    logic [W-1:0]  taps_q, taps_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [W-1:0]  key_c;
    logic [W-1:0]  src_c;
    logic          lfsr_load_c;
    logic          lfsr_step_c;
    logic          load_out_c;
    logic          in_ready_c;
    logic          free_c;
    logic          in_pre_c;
    logic          pos_live_c;
    logic          cfg_bad_c;

`ifdef LSC_CFG_CHECK_EN
    assign cfg_bad_c = (cfg_seed == '0) || ((W == 8) && !is_max_taps8(8'(cfg_taps)));
`else
    assign cfg_bad_c = 1'b0;
`endif

    assign free_c     = !out_valid_q || bus.out_ready;
    assign in_pre_c   = pos_q < pre_q;
    assign pos_live_c = pos_q < PW'(FRAME);

    lsc_lfsr #(.W(W)) u_lfsr (
        .clk  (clk),
        .rst  (init),
        .load (lfsr_load_c),
        .seed (cfg_seed),
        .step (lfsr_step_c),
        .taps (taps_q),
        .q    (key_c)
    );

    // Next-state, position consumption and output-register load.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pre_d       = pre_q;
        mode_d      = mode_q;
        msg_end_d   = msg_end_q;
        taps_d      = taps_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = done_q;
        err_d       = err_q;
        src_c       = bus.in_data;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;
        load_out_c  = 1'b0;
        in_ready_c  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (cfg_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = RUN;
                        mode_d      = cfg_mode;
                        taps_d      = cfg_taps;
                        pre_d       = cfg_pre;
                        pos_d       = '0;
                        msg_end_d   = 1'b0;
                        done_d      = 1'b0;
                        lfsr_load_c = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pos_live_c) begin
                    if (!mode_q) begin
                        if (in_pre_c || msg_end_q) begin
                            src_c      = PAD_CHAR;
                            load_out_c = free_c;
                        end else begin
                            in_ready_c = free_c;
                            load_out_c = bus.in_valid && free_c;
                            if (load_out_c && bus.in_last) begin
                                msg_end_d = 1'b1;
                            end
                        end
                        lfsr_step_c = load_out_c;
                    end else begin
                        // Preamble bytes are swallowed even while the output is stalled.
                        in_ready_c  = in_pre_c || free_c;
                        lfsr_step_c = bus.in_valid && in_ready_c;
                        load_out_c  = lfsr_step_c && !in_pre_c;
                    end
                    if (lfsr_step_c) begin
                        pos_d = pos_q + PW'(1);
                    end
                end else if (!out_valid_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_out_c) begin
            out_valid_d = 1'b1;
            out_data_d  = src_c ^ key_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            pre_q       <= '0;
            mode_q      <= 1'b0;
            msg_end_q   <= 1'b0;
            taps_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            pre_q       <= pre_d;
            mode_q      <= mode_d;
            msg_end_q   <= msg_end_d;
            taps_q      <= taps_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Scoreboard bench for lfsr_stream_cipher: a frame-level reference model fills an expected
// queue; an independent monitor pops it on every output handshake.
module tb_lfsr_stream_cipher;

    localparam int unsigned W     = 8;
    localparam int unsigned FRAME = 64;
    localparam int unsigned PW    = $clog2(FRAME + 1);

    logic          clk = 1'b0;
    logic          init;
    logic          start;
    logic          cfg_mode;
    logic [W-1:0]  cfg_taps;
    logic [W-1:0]  cfg_seed;
    logic [PW-1:0] cfg_pre;
    logic          done;
    logic          err;

    lfsr_stream_cipher_if #(.W(W)) bus ();

    lfsr_stream_cipher #(.W(W), .FRAME(FRAME)) dut (
        .clk      (clk),
        .init     (init),
        .start    (start),
        .cfg_mode (cfg_mode),
        .cfg_taps (cfg_taps),
        .cfg_seed (cfg_seed),
        .cfg_pre  (cfg_pre),
        .bus      (bus.slave),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q [$];
    logic [7:0] cap [$];
    logic [7:0] stim_q [$];
    logic [7:0] msg_q [$];
    logic [7:0] keys [FRAME];
    logic [7:0] frame_pt [FRAME];
    logic       saw_ready;

    localparam logic [7:0] TAB [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Key i is the i-th LFSR state: shift left, new LSB = parity of tapped bits.
    task automatic gen_keys(input logic [7:0] taps, input logic [7:0] seed);
        int k;
        k = seed;
        for (int i = 0; i < FRAME; i++) begin
            keys[i] = 8'(k);
            k = ((k * 2) % 256) + ($countones(8'(k) & taps) % 2);
        end
    endtask

    // Plaintext frame: pre pads, then the message (truncated), then pads; ciphertext expected.
    task automatic push_enc(input int pre);
        for (int i = 0; i < FRAME; i++) begin
            if (i < pre || (i - pre) >= msg_q.size()) frame_pt[i] = 8'h20;
            else frame_pt[i] = msg_q[i - pre];
            exp_q.push_back(frame_pt[i] ^ keys[i]);
        end
    endtask

    task automatic push_dec_plain(input int pre);
        for (int i = pre; i < FRAME; i++) exp_q.push_back(frame_pt[i]);
    endtask

    // Monitor: pops on each handshake and checks that stalled data is held.
    initial begin : monitor
        logic       held;
        logic [7:0] held_d;
        logic [7:0] e;
        held = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (init) begin
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, held_d});
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_out: got %0h, required no output", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e);
                    end
                    cap.push_back(bus.out_data);
                end
                held = bus.out_valid && !bus.out_ready;
                held_d = bus.out_data;
            end
        end
    end

    task automatic run(input logic mode, input logic [7:0] taps, input logic [7:0] seed,
                       input int pre, input bit bp, input int abort_at, input bit mid_start);
        int j;
        int cyc;
        cap.delete();
        saw_ready = 1'b0;
        @(posedge clk); #1;
        cfg_mode = mode; cfg_taps = taps; cfg_seed = seed; cfg_pre = PW'(pre);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j = 0;
        cyc = 0;
        forever begin
            bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (j < stim_q.size()) begin
                bus.in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = stim_q[j];
                bus.in_last  = !mode && (j == stim_q.size() - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'b0;
            end
            if (mid_start) start = (cyc == 5);
            @(negedge clk);
            if (bus.in_ready) saw_ready = 1'b1;
            if (bus.in_valid && bus.in_ready) j++;
            if (done) break;
            if (abort_at > 0 && cap.size() >= abort_at) break;
            cyc++;
            if (cyc > 2000) begin
                n_chk++;
                $display("FAIL run_timeout: got no done after %0d cycles, required done", cyc);
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int exp_n);
        @(negedge clk);
        chk({name, "_count"}, cap.size(), exp_n);
        chk({name, "_qempty"}, exp_q.size(), 0);
        chk({name, "_done"}, done, 1'b1);
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: got hang, required completion");
        $fatal(1);
    end

    initial begin : stim
        string      s;
        logic [7:0] cipher1 [$];
        logic [7:0] tp, sd;
        int         pre, len;

        init = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_taps = '0; cfg_seed = '0; cfg_pre = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        init = 1'b0;

        s = "Mr. Watson, come here. I want to see you.";
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);

        // Test 1: encrypt reference frame.
        gen_keys(8'hd4, 8'h41);
        stim_q = msg_q;
        push_enc(9);
        run(1'b0, 8'hd4, 8'h41, 9, 1'b0, 0, 1'b0);
        finish_run("t1", 64);
        chk("t1_out0", cap[0], 8'h61);
        chk("t1_out1", cap[1], 8'ha3);
        cipher1 = cap;

        // Test 2: decrypt it back.
        stim_q = cipher1;
        push_dec_plain(9);
        run(1'b1, 8'hd4, 8'h41, 9, 1'b0, 0, 1'b0);
        finish_run("t2", 55);
        chk("t2_last", cap[54], 8'h20);

        // Test 3: test 1 under backpressure and random in_valid.
        stim_q = msg_q;
        push_enc(9);
        run(1'b0, 8'hd4, 8'h41, 9, 1'b1, 0, 1'b0);
        finish_run("t3", 64);

        // Test 4: all-preamble encrypt, then full-frame decrypt.
        push_enc(64);
        run(1'b0, 8'hd4, 8'h41, 64, 1'b0, 0, 1'b0);
        finish_run("t4a", 64);
        chk("t4a_no_ready", saw_ready, 1'b0);
        stim_q.delete();
        for (int i = 0; i < FRAME; i++) begin
            stim_q.push_back(8'($urandom));
            exp_q.push_back(stim_q[i] ^ keys[i]);
        end
        run(1'b1, 8'hd4, 8'h41, 0, 1'b1, 0, 1'b0);
        finish_run("t4b", 64);

        // Test 5: reset mid-run, then a clean rerun with a start pulse during RUN.
        stim_q = msg_q;
        push_enc(9);
        run(1'b0, 8'hd4, 8'h41, 9, 1'b0, 20, 1'b0);
        @(posedge clk); #3;
        init = 1'b1;
        #1;
        chk("t5_rst_valid", bus.out_valid, 1'b0);
        chk("t5_rst_data", bus.out_data, 8'h00);
        chk("t5_rst_ready", bus.in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        init = 1'b0;
        push_enc(9);
        run(1'b0, 8'hd4, 8'h41, 9, 1'b0, 0, 1'b1);
        finish_run("t5", 64);
        chk("t5_out0", cap[0], 8'h61);

        // Random round trips, including truncation and oversized preambles.
        for (int r = 0; r < 4; r++) begin
`ifdef LSC_CFG_CHECK_EN
            tp = TAB[$urandom_range(0, 7)];
`else
            tp = 8'($urandom);
`endif
            sd  = 8'($urandom_range(1, 255));
            pre = $urandom_range(0, 70);
            len = $urandom_range(1, 70);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(33, 126)));
            gen_keys(tp, sd);
            stim_q = msg_q;
            push_enc(pre);
            run(1'b0, tp, sd, pre, 1'b1, 0, 1'b0);
            finish_run("rnd_enc", 64);
            stim_q = cap;
            push_dec_plain(pre);
            run(1'b1, tp, sd, pre, 1'b1, 0, 1'b0);
            finish_run("rnd_dec", pre >= FRAME ? 0 : FRAME - pre);
        end

`ifdef LSC_CFG_CHECK_EN
        // Rejected configurations keep the block idle and raise err.
        cap.delete();
        @(posedge clk); #1;
        cfg_mode = 1'b0; cfg_taps = 8'hd4; cfg_seed = 8'h00; cfg_pre = PW'(9); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_seed0_err", err, 1'b1);
        chk("t6_seed0_noout", cap.size(), 0);
        cfg_taps = 8'h8e; cfg_seed = 8'h41; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("t6_taps_err", err, 1'b1);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        gen_keys(8'hd4, 8'h41);
        stim_q = msg_q;
        push_enc(9);
        run(1'b0, 8'hd4, 8'h41, 9, 1'b0, 0, 1'b0);
        chk("t6_err_clear", err, 1'b0);
        finish_run("t6", 64);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
